cell_mem_sched: RTL and testbench

Scheduler for the single-port 256×16 cell memory. It serves two requesters: requester 0 is the evaluator core and requester 1 is the loader/debug port. Each request is a whole-cell transaction, either a 3-word cell read or a 3-word cell allocation. The block arbitrates round-robin, sequences the per-word memory accesses, owns the heap free pointer, and returns each result on a shared response bus with a per-requester ack.

---
 rtl/cell_mem_sched.sv | 268 ++++++++++++++++++++++++++
 tb/tb_cell_mem_sched.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cell_mem_sched.sv
// Round-robin scheduler for the single-port cell memory: whole-cell reads
// and heap allocations for the evaluator core and the loader/debug port.
module cell_mem_sched #(
    parameter int                   AddrWidth  = 8,
    parameter int                   DataWidth  = 16,
    parameter int                   MemorySize = 256,
    parameter logic [AddrWidth-1:0] HeapBase   = 8'h20
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           req,
    input  logic [1:0]           alloc,
    input  logic [AddrWidth-1:0] ptr0,
    input  logic [AddrWidth-1:0] ptr1,
    input  logic [DataWidth-1:0] wtype0,
    input  logic [DataWidth-1:0] wcar0,
    input  logic [DataWidth-1:0] wcdr0,
    input  logic [DataWidth-1:0] wtype1,
    input  logic [DataWidth-1:0] wcar1,
    input  logic [DataWidth-1:0] wcdr1,
    output logic [1:0]           ack,
    output logic [DataWidth-1:0] rsp_type,
    output logic [DataWidth-1:0] rsp_car,
    output logic [DataWidth-1:0] rsp_cdr,
    output logic [AddrWidth-1:0] rsp_ptr,
    output logic                 rsp_err,
    output logic                 busy,
    output logic [AddrWidth-1:0] free_ptr,
    output logic [AddrWidth-1:0] mem_addr,
    output logic                 mem_we,
    output logic [DataWidth-1:0] mem_wdata,
    input  logic [DataWidth-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_DONE
    } state_t;

    state_t               r_state;
    state_t               w_state_n;
    logic [1:0]           r_cnt;
    logic [1:0]           w_cnt_n;
    logic                 r_last;
    logic                 w_last_n;
    logic                 r_grant;
    logic                 w_grant_n;
    logic [AddrWidth-1:0] r_ptr;
    logic [AddrWidth-1:0] w_ptr_n;
    logic [DataWidth-1:0] r_wtype;
    logic [DataWidth-1:0] w_wtype_n;
    logic [DataWidth-1:0] r_wcar;
    logic [DataWidth-1:0] w_wcar_n;
    logic [AddrWidth-1:0] r_free;
    logic [AddrWidth-1:0] w_free_n;
    logic [1:0]           r_ack;
    logic [1:0]           w_ack_n;
    logic                 r_busy;
    logic                 w_busy_n;
    logic [AddrWidth-1:0] r_mem_addr;
    logic [AddrWidth-1:0] w_mem_addr_n;
    logic                 r_mem_we;
    logic                 w_mem_we_n;
    logic [DataWidth-1:0] r_mem_wdata;
    logic [DataWidth-1:0] w_mem_wdata_n;
    logic [DataWidth-1:0] r_rsp_type;
    logic [DataWidth-1:0] w_rsp_type_n;
    logic [DataWidth-1:0] r_rsp_car;
    logic [DataWidth-1:0] w_rsp_car_n;
    logic [DataWidth-1:0] r_rsp_cdr;
    logic [DataWidth-1:0] w_rsp_cdr_n;
    logic [AddrWidth-1:0] r_rsp_ptr;
    logic [AddrWidth-1:0] w_rsp_ptr_n;
    logic                 r_rsp_err;
    logic                 w_rsp_err_n;

    logic                 w_gnt;
    logic                 w_gop;
    logic [AddrWidth-1:0] w_gptr;
    logic [DataWidth-1:0] w_gtype;
    logic [DataWidth-1:0] w_gcar;
    logic [DataWidth-1:0] w_gcdr;
    logic [1:0]           w_gack;
    logic [1:0]           w_rack;
    logic [AddrWidth:0]   w_top;
    logic                 w_full;

    // On a tie, favour whichever requester did not win last time.
    always_comb begin
        w_gnt = 1'b0;
        unique case (req)
            2'b01:   w_gnt = 1'b0;
            2'b10:   w_gnt = 1'b1;
            2'b11:   w_gnt = ~r_last;
            default: w_gnt = 1'b0;
        endcase
    end

    assign w_gop   = alloc[w_gnt];
    assign w_gptr  = w_gnt ? ptr1 : ptr0;
    assign w_gtype = w_gnt ? wtype1 : wtype0;
    assign w_gcar  = w_gnt ? wcar1 : wcar0;
    assign w_gcdr  = w_gnt ? wcdr1 : wcdr0;
    assign w_gack  = w_gnt ? 2'b10 : 2'b01;
    assign w_rack  = r_grant ? 2'b10 : 2'b01;

    // Extra bit so a heap near the top of memory cannot wrap into a pass.
    assign w_top  = {1'b0, r_free} + (AddrWidth+1)'(2);
    assign w_full = w_top > (AddrWidth+1)'(MemorySize - 1);

    always_comb begin
        w_state_n     = r_state;
        w_cnt_n       = r_cnt;
        w_last_n      = r_last;
        w_grant_n     = r_grant;
        w_ptr_n       = r_ptr;
        w_wtype_n     = r_wtype;
        w_wcar_n      = r_wcar;
        w_free_n      = r_free;
        w_ack_n       = 2'b00;
        w_mem_addr_n  = '0;
        w_mem_we_n    = 1'b0;
        w_mem_wdata_n = '0;
        w_rsp_type_n  = r_rsp_type;
        w_rsp_car_n   = r_rsp_car;
        w_rsp_cdr_n   = r_rsp_cdr;
        w_rsp_ptr_n   = r_rsp_ptr;
        w_rsp_err_n   = r_rsp_err;
        unique case (r_state)
            S_IDLE: begin
                if (|req) begin
                    w_grant_n = w_gnt;
                    w_last_n  = w_gnt;
                    w_ptr_n   = w_gptr;
                    w_wtype_n = w_gtype;
                    w_wcar_n  = w_gcar;
                    w_cnt_n   = 2'd0;
                    if (!w_gop) begin
                        if (w_gptr < AddrWidth'(2)) begin
                            w_state_n   = S_DONE;
                            w_rsp_err_n = 1'b1;
                            w_ack_n     = w_gack;
                        end else begin
                            w_state_n    = S_READ;
                            w_rsp_err_n  = 1'b0;
                            w_mem_addr_n = w_gptr;
                        end
                    end else if (w_full) begin
                        w_state_n   = S_DONE;
                        w_rsp_err_n = 1'b1;
                        w_ack_n     = w_gack;
                    end else begin
                        w_state_n     = S_WRITE;
                        w_rsp_err_n   = 1'b0;
                        w_mem_we_n    = 1'b1;
                        w_mem_addr_n  = r_free;
                        w_mem_wdata_n = w_gcdr;
                    end
                end
            end
            S_READ: begin
                w_cnt_n = r_cnt + 2'd1;
                // Read data trails its address by one cycle.
                unique case (r_cnt)
                    2'd0: w_mem_addr_n = r_ptr - AddrWidth'(1);
                    2'd1: begin
                        w_mem_addr_n = r_ptr - AddrWidth'(2);
                        w_rsp_type_n = mem_rdata;
                    end
                    2'd2: w_rsp_car_n = mem_rdata;
                    2'd3: begin
                        w_rsp_cdr_n = mem_rdata;
                        w_state_n   = S_DONE;
                        w_ack_n     = w_rack;
                    end
                    default: w_cnt_n = 2'd0;
                endcase
            end
            S_WRITE: begin
                w_cnt_n = r_cnt + 2'd1;
                unique case (r_cnt)
                    2'd0: begin
                        w_mem_we_n    = 1'b1;
                        w_mem_addr_n  = r_free + AddrWidth'(1);
                        w_mem_wdata_n = r_wcar;
                    end
                    2'd1: begin
                        w_mem_we_n    = 1'b1;
                        w_mem_addr_n  = r_free + AddrWidth'(2);
                        w_mem_wdata_n = r_wtype;
                    end
                    default: begin
                        w_free_n    = r_free + AddrWidth'(3);
                        w_rsp_ptr_n = r_free + AddrWidth'(2);
                        w_state_n   = S_DONE;
                        w_ack_n     = w_rack;
                    end
                endcase
            end
            S_DONE: begin
                w_state_n = S_IDLE;
                w_cnt_n   = 2'd0;
            end
            default: begin
                w_state_n = S_IDLE;
                w_cnt_n   = 2'd0;
            end
        endcase
        w_busy_n = (w_state_n != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= 2'd0;
            r_last      <= 1'b1;
            r_grant     <= 1'b0;
            r_ptr       <= '0;
            r_wtype     <= '0;
            r_wcar      <= '0;
            r_free      <= HeapBase;
            r_ack       <= 2'b00;
            r_busy      <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_we    <= 1'b0;
            r_mem_wdata <= '0;
            r_rsp_type  <= '0;
            r_rsp_car   <= '0;
            r_rsp_cdr   <= '0;
            r_rsp_ptr   <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_cnt       <= w_cnt_n;
            r_last      <= w_last_n;
            r_grant     <= w_grant_n;
            r_ptr       <= w_ptr_n;
            r_wtype     <= w_wtype_n;
            r_wcar      <= w_wcar_n;
            r_free      <= w_free_n;
            r_ack       <= w_ack_n;
            r_busy      <= w_busy_n;
            r_mem_addr  <= w_mem_addr_n;
            r_mem_we    <= w_mem_we_n;
            r_mem_wdata <= w_mem_wdata_n;
            r_rsp_type  <= w_rsp_type_n;
            r_rsp_car   <= w_rsp_car_n;
            r_rsp_cdr   <= w_rsp_cdr_n;
            r_rsp_ptr   <= w_rsp_ptr_n;
            r_rsp_err   <= w_rsp_err_n;
        end
    end

    assign ack       = r_ack;
    assign busy      = r_busy;
    assign free_ptr  = r_free;
    assign mem_addr  = r_mem_addr;
    assign mem_we    = r_mem_we;
    assign mem_wdata = r_mem_wdata;
    assign rsp_type  = r_rsp_type;
    assign rsp_car   = r_rsp_car;
    assign rsp_cdr   = r_rsp_cdr;
    assign rsp_ptr   = r_rsp_ptr;
    assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_cell_mem_sched.sv
// Directed bench for cell_mem_sched: reads, allocations, errors,
// fairness, reset abort and a cons-list walk over a behavioural RAM.
module tb_cell_mem_sched;

    localparam logic [15:0] NIL    = 16'h0000;
    localparam logic [15:0] T_NUM  = 16'h0001;
    localparam logic [15:0] T_CONS = 16'h0002;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  req = 2'b00;
    logic [1:0]  alloc = 2'b00;
    logic [7:0]  ptr0 = '0, ptr1 = '0;
    logic [15:0] wtype0 = '0, wcar0 = '0, wcdr0 = '0;
    logic [15:0] wtype1 = '0, wcar1 = '0, wcdr1 = '0;
    logic [1:0]  ack;
    logic [15:0] rsp_type, rsp_car, rsp_cdr;
    logic [7:0]  rsp_ptr, free_ptr, mem_addr;
    logic        rsp_err, busy, mem_we;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;

    cell_mem_sched u_dut (
        .clk(clk), .rst(rst), .req(req), .alloc(alloc),
        .ptr0(ptr0), .ptr1(ptr1),
        .wtype0(wtype0), .wcar0(wcar0), .wcdr0(wcdr0),
        .wtype1(wtype1), .wcar1(wcar1), .wcdr1(wcdr1),
        .ack(ack), .rsp_type(rsp_type), .rsp_car(rsp_car),
        .rsp_cdr(rsp_cdr), .rsp_ptr(rsp_ptr), .rsp_err(rsp_err),
        .busy(busy), .free_ptr(free_ptr), .mem_addr(mem_addr),
        .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Second instance with the heap placed at the very top of memory.
    logic [1:0]  req_h = 2'b00, alloc_h = 2'b00;
    logic [7:0]  hp = 8'h00;
    logic [15:0] hd = 16'h1234;
    logic [15:0] zero16 = 16'h0000;
    logic [1:0]  ack_h;
    logic [15:0] rsp_type_h, rsp_car_h, rsp_cdr_h, mem_wdata_h;
    logic [7:0]  rsp_ptr_h, free_ptr_h, mem_addr_h;
    logic        rsp_err_h, busy_h, mem_we_h;

    cell_mem_sched #(.HeapBase(8'hFE)) u_dut_hi (
        .clk(clk), .rst(rst), .req(req_h), .alloc(alloc_h),
        .ptr0(hp), .ptr1(hp),
        .wtype0(hd), .wcar0(hd), .wcdr0(hd),
        .wtype1(hd), .wcar1(hd), .wcdr1(hd),
        .ack(ack_h), .rsp_type(rsp_type_h), .rsp_car(rsp_car_h),
        .rsp_cdr(rsp_cdr_h), .rsp_ptr(rsp_ptr_h), .rsp_err(rsp_err_h),
        .busy(busy_h), .free_ptr(free_ptr_h), .mem_addr(mem_addr_h),
        .mem_we(mem_we_h), .mem_wdata(mem_wdata_h), .mem_rdata(zero16)
    );

    logic [15:0] mem [0:255];
    logic        bd_we = 1'b0;
    logic [7:0]  bd_addr = '0;
    logic [15:0] bd_data = '0;

    always @(posedge clk) begin
        if (bd_we) mem[bd_addr] <= bd_data;
        else if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    int n_vec = 0;
    int n_bad = 0;
    int lat, nwe, n, nack, n_ovl, n_wide;
    int ord [4];
    int when [4];
    logic [1:0]  prev;
    logic [15:0] s_type, s_car, s_cdr;
    logic [7:0]  s_ptr, s_free;
    logic        s_err;
    logic [7:0]  n1, n2, n3, c1, c2, c3, cp, np;
    logic [15:0] nx;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic bd(input logic [7:0] a, input logic [15:0] d);
        bd_addr = a;
        bd_data = d;
        bd_we   = 1'b1;
        @(negedge clk);
        bd_we   = 1'b0;
    endtask

    // Call in an Idle cycle; returns one cycle after the ack, back in Idle.
    task automatic txn(input int r, input logic al, input logic [7:0] p,
                       input logic [15:0] t, input logic [15:0] c,
                       input logic [15:0] d, output int lt, output int nw);
        lt = 99;
        nw = 0;
        if (r == 0) begin
            ptr0 = p; wtype0 = t; wcar0 = c; wcdr0 = d;
        end else begin
            ptr1 = p; wtype1 = t; wcar1 = c; wcdr1 = d;
        end
        alloc[r[0]] = al;
        req[r[0]]   = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (mem_we) nw++;
            if (ack[r[0]]) begin
                lt     = i;
                s_type = rsp_type;
                s_car  = rsp_car;
                s_cdr  = rsp_cdr;
                s_ptr  = rsp_ptr;
                s_err  = rsp_err;
                s_free = free_ptr;
                break;
            end
        end
        req[r[0]] = 1'b0;
        @(negedge clk);
        chk("ack_width", ack, 2'b00);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        @(negedge clk);
        @(negedge clk);
        chk("rst_ack", ack, 2'b00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_free", free_ptr, 8'h20);
        chk("rst_we", mem_we, 1'b0);
        chk("rst_addr", mem_addr, 8'h00);
        chk("rst_err", rsp_err, 1'b0);
        chk("rst_ptr", rsp_ptr, 8'h00);
        bd(8'h00, 16'hBEEF);
        bd(8'h01, NIL);
        bd(8'h02, 16'hDEAD);
        bd(8'h03, T_NUM);
        bd(8'h20, 16'hFFFF);
        rst = 1'b1;
        @(negedge clk);

        txn(0, 1'b0, 8'h03, 0, 0, 0, lat, nwe);
        chk("rd_lat", lat, 5);
        chk("rd_type", s_type, T_NUM);
        chk("rd_car", s_car, 16'hDEAD);
        chk("rd_cdr", s_cdr, NIL);
        chk("rd_err", s_err, 1'b0);
        chk("rd_nwe", nwe, 0);

        txn(1, 1'b1, 8'h00, T_CONS, 16'h0006, NIL, lat, nwe);
        chk("al_lat", lat, 4);
        chk("al_ptr", s_ptr, 8'h22);
        chk("al_free", s_free, 8'h23);
        chk("al_err", s_err, 1'b0);
        chk("al_nwe", nwe, 3);
        chk("al_m20", mem[8'h20], NIL);
        chk("al_m21", mem[8'h21], 16'h0006);
        chk("al_m22", mem[8'h22], T_CONS);

        txn(0, 1'b0, 8'h01, 0, 0, 0, lat, nwe);
        chk("e1_lat", lat, 1);
        chk("e1_err", s_err, 1'b1);
        chk("e1_nwe", nwe, 0);

        txn(1, 1'b0, 8'h02, 0, 0, 0, lat, nwe);
        chk("p2_lat", lat, 5);
        chk("p2_err", s_err, 1'b0);
        chk("p2_type", s_type, 16'hDEAD);
        chk("p2_car", s_car, NIL);
        chk("p2_cdr", s_cdr, 16'hBEEF);

        chk("hi_free0", free_ptr_h, 8'hFE);
        req_h   = 2'b01;
        alloc_h = 2'b01;
        lat = 99;
        nwe = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (mem_we_h) nwe++;
            if (ack_h[0]) begin
                lat   = i;
                s_err = rsp_err_h;
                break;
            end
        end
        req_h = 2'b00;
        chk("hi_lat", lat, 1);
        chk("hi_err", s_err, 1'b1);
        chk("hi_nwe", nwe, 0);
        chk("hi_free", free_ptr_h, 8'hFE);
        @(negedge clk);

        ptr0     = 8'h03;
        alloc[0] = 1'b0;
        req[0]   = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("mr_busy", busy, 1'b1);
        chk("mr_addr", mem_addr, 8'h02);
        #1 rst = 1'b0;
        #1;
        chk("mr_busy0", busy, 1'b0);
        chk("mr_addr0", mem_addr, 8'h00);
        chk("mr_free", free_ptr, 8'h20);
        chk("mr_type", rsp_type, 16'h0000);
        chk("mr_ptr", rsp_ptr, 8'h00);
        req[0] = 1'b0;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n += (ack != 2'b00) ? 1 : 0;
        end
        chk("mr_noack", n, 0);
        rst = 1'b1;
        @(negedge clk);
        txn(0, 1'b0, 8'h03, 0, 0, 0, lat, nwe);
        chk("mr2_lat", lat, 5);
        chk("mr2_type", s_type, T_NUM);
        chk("mr2_car", s_car, 16'hDEAD);

        rst   = 1'b0;
        req   = 2'b11;
        alloc = 2'b00;
        ptr0  = 8'h03;
        ptr1  = 8'h03;
        @(negedge clk);
        rst    = 1'b1;
        nack   = 0;
        n_ovl  = 0;
        n_wide = 0;
        prev   = 2'b00;
        for (int i = 1; i <= 60 && nack < 4; i++) begin
            @(negedge clk);
            if (ack == 2'b11) n_ovl++;
            if (ack != 2'b00 && prev != 2'b00) n_wide++;
            if (ack != 2'b00) begin
                ord[nack]  = ack[1] ? 1 : 0;
                when[nack] = i;
                nack++;
            end
            prev = ack;
        end
        req = 2'b00;
        @(negedge clk);
        chk("fr_count", nack, 4);
        chk("fr_ovl", n_ovl, 0);
        chk("fr_wide", n_wide, 0);
        chk("fr_g0", ord[0], 0);
        chk("fr_g1", ord[1], 1);
        chk("fr_g2", ord[2], 0);
        chk("fr_g3", ord[3], 1);
        chk("fr_t0", when[0], 5);
        chk("fr_t1", when[1], 11);
        chk("fr_t3", when[3], 23);

        txn(0, 1'b1, 8'h00, T_NUM, 16'd3, NIL, lat, nwe);
        chk("ls_a0", s_ptr, 8'h22);
        n3 = s_ptr;
        txn(1, 1'b1, 8'h00, T_CONS, {8'h00, n3}, NIL, lat, nwe);
        chk("ls_a1", s_ptr, 8'h25);
        c3 = s_ptr;
        txn(0, 1'b1, 8'h00, T_NUM, 16'd2, NIL, lat, nwe);
        chk("ls_a2", s_ptr, 8'h28);
        n2 = s_ptr;
        txn(1, 1'b1, 8'h00, T_CONS, {8'h00, n2}, {8'h00, c3}, lat, nwe);
        chk("ls_a3", s_ptr, 8'h2B);
        c2 = s_ptr;
        txn(0, 1'b1, 8'h00, T_NUM, 16'd1, NIL, lat, nwe);
        chk("ls_a4", s_ptr, 8'h2E);
        n1 = s_ptr;
        txn(1, 1'b1, 8'h00, T_CONS, {8'h00, n1}, {8'h00, c2}, lat, nwe);
        chk("ls_a5", s_ptr, 8'h31);
        chk("ls_free", s_free, 8'h32);
        c1 = s_ptr;
        cp = c1;
        nx = 16'hFFFF;
        for (int i = 0; i < 3; i++) begin
            txn(0, 1'b0, cp, 0, 0, 0, lat, nwe);
            chk("ls_ctype", s_type, T_CONS);
            np = s_car[7:0];
            nx = s_cdr;
            txn(1, 1'b0, np, 0, 0, 0, lat, nwe);
            chk("ls_ntype", s_type, T_NUM);
            chk("ls_car", s_car, i + 1);
            cp = nx[7:0];
        end
        chk("ls_nil", nx, NIL);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
